fetch_unit: RTL and testbench

Instruction-fetch front end: owns the program counter, drives the instruction-memory address port, and captures the instruction returned one cycle later into a small fetch queue. Decode drains the queue over a valid/ready handshake. A single-cycle redirect (branch/jump/exception) restarts fetch at a new PC. Sits directly upstream of the instruction memory and between it and decode.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_queue.sv | 56 +++++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int INSN_WIDTH      = 32;
  localparam int INSN_ADDR_WIDTH = 32;
  localparam int INSN_MEM_OFFSET = 2;
  localparam int INSN_BYTES      = 2 ** INSN_MEM_OFFSET;

  typedef logic [INSN_WIDTH-1:0]      InsnPath;
  typedef logic [INSN_ADDR_WIDTH-1:0] InsnAddrPath;

  typedef struct packed {
    InsnPath     insn;
    InsnAddrPath pc;
  } FetchEntry;

  // Clear the byte-offset bits so the address names a whole instruction.
  function automatic InsnAddrPath align_addr(input InsnAddrPath addr);
    return addr & ~InsnAddrPath'(INSN_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Small synchronous FIFO of fetched {insn, pc} entries with a flush that
// empties it in one cycle. Push on a full queue is only legal together with a pop.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  FetchEntry     push_entry,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output FetchEntry     head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  FetchEntry         entries [DEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;
  logic              do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign do_pop = pop && (count != '0);
  assign head   = entries[head_ptr];

  // Pointer, occupancy and storage update; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the entry array is reset too, because the head entry drives
      // outInsn/outPC directly and those must read zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        entries[tail_ptr] <= push_entry;
        tail_ptr          <= next_ptr(tail_ptr);
      end
      if (do_pop) head_ptr <= next_ptr(head_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the instruction-memory
// address, tracks the one outstanding request and buffers responses for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter InsnAddrPath RESET_PC    = '0,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output InsnAddrPath insnAddr,
  input  InsnPath     insn,
  input  logic        redirect,
  input  InsnAddrPath redirectPC,
  output logic        outValid,
  input  logic        outReady,
  output InsnPath     outInsn,
  output InsnAddrPath outPC
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  InsnAddrPath   pc;
  logic          inflight;
  InsnAddrPath   inflight_pc;
  InsnAddrPath   aligned_target;
  logic [CW-1:0] count;
  FetchEntry     head;
  FetchEntry     push_entry;
  logic          deq;
  logic          issue;
  logic          push;

  assign aligned_target = align_addr(redirectPC);
  assign deq            = outValid && outReady;
  assign push           = inflight && !redirect;
  assign push_entry     = '{insn: insn, pc: inflight_pc};

  assign outValid = (count != '0);
  assign outInsn  = head.insn;
  assign outPC    = head.pc;

  // Issue only if the response still has a guaranteed slot, counting the
  // request already in flight and the entry leaving this cycle.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    issue = 1'b0;
    if ((32'(count) + 32'(inflight) - 32'(deq)) < 32'(QUEUE_DEPTH)) issue = 1'b1;
  end

  // Memory samples this address on every edge; a redirect overrides it at once.
  always_comb begin
    insnAddr = pc;
    if (redirect) insnAddr = aligned_target;
  end

  // PC and in-flight tracking; a redirect restarts fetch at the target.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the pre-edge values of the others.
    if (!rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc          <= aligned_target + InsnAddrPath'(INSN_BYTES);
      inflight    <= 1'b1;
      inflight_pc <= aligned_target;
    end else begin
      inflight    <= issue;
      inflight_pc <= pc;
      if (issue) pc <= pc + InsnAddrPath'(INSN_BYTES);
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (deq),
    .flush      (redirect),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model (PC, one
// outstanding request, queue of fetched PCs) predicts every cycle's outputs.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RST_PC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] insnAddr;
  logic [31:0] insn;
  logic        redirect = 1'b0;
  logic [31:0] redirectPC = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] outInsn;
  logic [31:0] outPC;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_inflight;
  logic [31:0] m_inflight_pc;
  logic [31:0] m_q[$];

  logic [31:0] mem_addr = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) mem_addr <= insnAddr;
  assign insn = mem_word(mem_addr);

  fetch_unit #(
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .insnAddr   (insnAddr),
    .insn       (insn),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .outValid   (outValid),
    .outReady   (outReady),
    .outInsn    (outInsn),
    .outPC      (outPC)
  );

  task automatic model_reset();
    m_pc          = RST_PC;
    m_inflight    = 1'b0;
    m_inflight_pc = '0;
    m_q.delete();
  endtask

  // One clock cycle, entered and left just after a posedge: drive, compare
  // against the model, take the edge, advance the model.
  task automatic cycle(input logic r, input logic [31:0] rpc, input logic rdy,
                       output logic v, output logic [31:0] opc);
    logic        exp_v;
    logic [31:0] exp_addr;
    logic [31:0] tgt;
    logic        deq;
    int          occ;
    redirect   = r;
    redirectPC = rpc;
    outReady   = rdy;
    #1;
    tgt      = rpc & ~32'h3;
    exp_v    = (m_q.size() != 0);
    exp_addr = r ? tgt : m_pc;
    checks++;
    if (outValid !== exp_v) begin
      failures++;
      $display("FAIL cycle_valid t=%0t got=%b exp=%b", $time, outValid, exp_v);
    end
    checks++;
    if (insnAddr !== exp_addr) begin
      failures++;
      $display("FAIL cycle_addr t=%0t got=%h exp=%h", $time, insnAddr, exp_addr);
    end
    if (exp_v) begin
      checks++;
      if (outPC !== m_q[0]) begin
        failures++;
        $display("FAIL cycle_pc t=%0t got=%h exp=%h", $time, outPC, m_q[0]);
      end
      checks++;
      if (outInsn !== mem_word(m_q[0])) begin
        failures++;
        $display("FAIL cycle_insn t=%0t got=%h exp=%h", $time, outInsn, mem_word(m_q[0]));
      end
    end
    v   = outValid;
    opc = outPC;
    deq = exp_v && rdy;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_inflight    = 1'b1;
      m_inflight_pc = tgt;
      m_pc          = tgt + 32'd4;
    end else begin
      occ = m_q.size() + int'(m_inflight) - int'(deq);
      if (deq) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back(m_inflight_pc);
      m_inflight_pc = m_pc;
      m_inflight    = (occ < DEPTH);
      if (occ < DEPTH) m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  // Run with outReady = 1 until a valid head appears, within a bound.
  task automatic first_valid(input int bound, output logic found, output logic [31:0] pc);
    logic        v;
    logic [31:0] p;
    found = 1'b0;
    pc    = '0;
    for (int i = 0; i < bound && !found; i++) begin
      cycle(1'b0, '0, 1'b1, v, p);
      if (v) begin
        found = 1'b1;
        pc    = p;
      end
    end
  endtask

  task automatic apply_reset();
    redirect = 1'b0;
    outReady = 1'b0;
    rst      = 1'b0;
    #1;
    model_reset();
    checks++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", outValid);
    end
    checks++;
    if (outInsn !== 32'h0 || outPC !== 32'h0) begin
      failures++;
      $display("FAIL reset_head insn=%h pc=%h exp=0/0", outInsn, outPC);
    end
    checks++;
    if (insnAddr !== RST_PC) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=%h", insnAddr, RST_PC);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_stream();
    logic        v;
    logic [31:0] p;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, '0, 1'b1, v, p);
      checks++;
      if (k < 2 ? (v !== 1'b0) : (v !== 1'b1 || p !== RST_PC + 32'(4 * (k - 2)))) begin
        failures++;
        $display("FAIL stream k=%0d valid=%b pc=%h", k, v, p);
      end
    end
  endtask

  task automatic test_backpressure();
    logic        v;
    logic [31:0] p;
    apply_reset();
    for (int k = 0; k < 6; k++) cycle(1'b0, '0, 1'b0, v, p);
    checks++;
    if (insnAddr !== 32'h8) begin
      failures++;
      $display("FAIL bp_stall_addr got=%h exp=00000008", insnAddr);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, 1'b1, v, p);
      checks++;
      if (v !== 1'b1 || p !== 32'(4 * k)) begin
        failures++;
        $display("FAIL bp_drain k=%0d valid=%b pc=%h exp=%h", k, v, p, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    logic        v;
    logic [31:0] p;
    logic        found;
    apply_reset();
    for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1, v, p);
    cycle(1'b1, 32'h40, 1'b1, v, p);
    first_valid(4, found, p);
    checks++;
    if (!found || p !== 32'h40) begin
      failures++;
      $display("FAIL redirect_first found=%b pc=%h exp=00000040", found, p);
    end
    cycle(1'b0, '0, 1'b1, v, p);
    checks++;
    if (v !== 1'b1 || p !== 32'h44) begin
      failures++;
      $display("FAIL redirect_second valid=%b pc=%h exp=00000044", v, p);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, 1'b1, v, p);
      checks++;
      if (v && p < 32'h48) begin
        failures++;
        $display("FAIL redirect_stale pc=%h", p);
      end
    end
  endtask

  task automatic test_unaligned();
    logic        v;
    logic [31:0] p;
    logic        found;
    cycle(1'b1, 32'h43, 1'b1, v, p);
    first_valid(4, found, p);
    checks++;
    if (!found || p !== 32'h40) begin
      failures++;
      $display("FAIL unaligned found=%b pc=%h exp=00000040", found, p);
    end
  endtask

  task automatic test_back_to_back();
    logic        v;
    logic [31:0] p;
    logic        found;
    cycle(1'b1, 32'h100, 1'b1, v, p);
    cycle(1'b1, 32'h200, 1'b1, v, p);
    first_valid(4, found, p);
    checks++;
    if (!found || p !== 32'h200) begin
      failures++;
      $display("FAIL b2b_first found=%b pc=%h exp=00000200", found, p);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, 1'b1, v, p);
      checks++;
      if (v && (p < 32'h204 || p > 32'h220)) begin
        failures++;
        $display("FAIL b2b_stream pc=%h", p);
      end
    end
  endtask

  task automatic test_wrap_and_mid_reset();
    logic        v;
    logic [31:0] p;
    logic        found;
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1, v, p);
    first_valid(4, found, p);
    checks++;
    if (!found || p !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_top found=%b pc=%h exp=fffffffc", found, p);
    end
    cycle(1'b0, '0, 1'b1, v, p);
    checks++;
    if (v !== 1'b1 || p !== 32'h0) begin
      failures++;
      $display("FAIL wrap_zero valid=%b pc=%h exp=00000000", v, p);
    end
    cycle(1'b0, '0, 1'b1, v, p);
    apply_reset();
    first_valid(4, found, p);
    checks++;
    if (!found || p !== RST_PC) begin
      failures++;
      $display("FAIL restart found=%b pc=%h exp=%h", found, p, RST_PC);
    end
  endtask

  task automatic test_random();
    logic        v;
    logic [31:0] p;
    logic        r;
    logic [31:0] rpc;
    apply_reset();
    for (int k = 0; k < 2000; k++) begin
      r   = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
      cycle(r, rpc, ($urandom_range(0, 3) != 0), v, p);
      if (k == 1000) apply_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_unaligned();
    test_back_to_back();
    test_wrap_and_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
